// File: rtl/sum_rr_arbiter.sv
// Round-robin front end that shares one pipelined summer between NUM_REQ requesters.
// Issued operations are tagged in an in-order FIFO so each returned sum can be
// routed back to the requester that owns it. A credit counter bounds the number
// of outstanding operations, and the FSM can stop granting and drain on request.
module sum_rr_arbiter #(
    parameter  int unsigned NUM_REQ      = 4,
    parameter  int unsigned NUM_INPUTS   = 16,
    parameter  int unsigned DWIDTH       = 14,
    parameter  int unsigned MAX_INFLIGHT = 8,
    localparam int unsigned IDW          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int unsigned CW           = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 i_enable,
    input  logic [NUM_REQ-1:0]                   i_req,
    input  logic [NUM_REQ*NUM_INPUTS*DWIDTH-1:0] i_req_dat,
    output logic [NUM_REQ-1:0]                   o_gnt,
    output logic [NUM_INPUTS*DWIDTH-1:0]         o_sum_dat_vector,
    output logic                                 o_sum_dat_valid,
    input  logic [DWIDTH-1:0]                    i_sum,
    input  logic                                 i_sum_valid,
    output logic [DWIDTH-1:0]                    o_rsp_sum,
    output logic [IDW-1:0]                       o_rsp_id,
    output logic                                 o_rsp_valid,
    output logic [CW-1:0]                        o_inflight,
    output logic                                 o_idle,
    output logic                                 o_err
);

    localparam int unsigned VW = NUM_INPUTS * DWIDTH;
    localparam int unsigned AW = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [IDW-1:0]     rr_ptr;
    logic [NUM_REQ-1:0] eligible;
    logic               win_found;
    logic [IDW-1:0]     win_id;
    logic [IDW-1:0]     ptr_nxt;
    logic [VW-1:0]      win_dat;
    logic               issue;
    logic               pop;
    logic               fifo_empty;

    logic [IDW-1:0]     tag_mem [MAX_INFLIGHT];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;

    assign fifo_empty = (o_inflight == '0);

    // Next-state logic, round-robin winner selection and issue/pop decisions
    always_comb begin
        state_nxt = state;
        eligible  = i_req & ~o_gnt;
        win_found = 1'b0;
        win_id    = '0;
        win_dat   = '0;
        ptr_nxt   = rr_ptr;
        issue     = 1'b0;
        pop       = 1'b0;

        case (state)
            ST_IDLE: begin
                if (i_enable) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (!i_enable) state_nxt = fifo_empty ? ST_IDLE : ST_DRAIN;
            end
            ST_DRAIN: begin
                if (i_enable)        state_nxt = ST_RUN;
                else if (fifo_empty) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase

        // first eligible requester at or above the pointer, wrapping around
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!win_found && eligible[(32'(rr_ptr) + i) % NUM_REQ]) begin
                win_found = 1'b1;
                win_id    = IDW'((32'(rr_ptr) + i) % NUM_REQ);
            end
        end

        for (int unsigned r = 0; r < NUM_REQ; r++) begin
            if (win_id == IDW'(r)) win_dat = i_req_dat[r*VW +: VW];
        end

        ptr_nxt = (win_id == IDW'(NUM_REQ - 1)) ? '0 : win_id + IDW'(1);

        issue = (state == ST_RUN) && i_enable && win_found &&
                (o_inflight < CW'(MAX_INFLIGHT));
        pop   = i_sum_valid && !fifo_empty;
    end

    // State, pointer, issue-side outputs and credit counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= ST_IDLE;
            rr_ptr           <= '0;
            o_gnt            <= '0;
            o_sum_dat_valid  <= 1'b0;
            o_sum_dat_vector <= '0;
            o_inflight       <= '0;
            o_idle           <= 1'b1;
            wr_ptr           <= '0;
            rd_ptr           <= '0;
        end else begin
            state           <= state_nxt;
            o_idle          <= (state_nxt == ST_IDLE);
            o_gnt           <= '0;
            o_sum_dat_valid <= 1'b0;
            if (issue) begin
                o_gnt            <= NUM_REQ'(1) << win_id;
                o_sum_dat_valid  <= 1'b1;
                o_sum_dat_vector <= win_dat;
                rr_ptr           <= ptr_nxt;
                wr_ptr           <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            case ({issue, pop})
                2'b10:   o_inflight <= o_inflight + CW'(1);
                2'b01:   o_inflight <= o_inflight - CW'(1);
                default: o_inflight <= o_inflight;
            endcase
        end
    end

    // Tag storage; contents are qualified by the pointers so no reset is needed
    always_ff @(posedge clk) begin
        if (issue) tag_mem[wr_ptr] <= win_id;
    end

    // Response path: one-cycle registered return of the summer result and its owner
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_rsp_valid <= 1'b0;
            o_rsp_sum   <= '0;
            o_rsp_id    <= '0;
            o_err       <= 1'b0;
        end else begin
            o_rsp_valid <= pop;
            if (pop) begin
                o_rsp_sum <= i_sum;
                o_rsp_id  <= tag_mem[rd_ptr];
            end
            if (i_sum_valid && fifo_empty) o_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sum_rr_arbiter.sv
// Directed bench for sum_rr_arbiter with a behavioural pipelined summer that can be
// replaced by a manually driven stub for credit/drain/error scenarios.
module tb_sum_rr_arbiter;

    localparam int NR  = 4;
    localparam int NI  = 16;
    localparam int DW  = 14;
    localparam int LAT = 4;

    logic                clk = 1'b0;
    logic                rst_n = 1'b1;
    logic                i_enable;
    logic [NR-1:0]       i_req;
    logic [NR*NI*DW-1:0] i_req_dat;
    logic [NR-1:0]       o_gnt;
    logic [NI*DW-1:0]    o_sum_dat_vector;
    logic                o_sum_dat_valid;
    logic [DW-1:0]       i_sum;
    logic                i_sum_valid;
    logic [DW-1:0]       o_rsp_sum;
    logic [1:0]          o_rsp_id;
    logic                o_rsp_valid;
    logic [3:0]          o_inflight;
    logic                o_idle;
    logic                o_err;

    logic                stub_mode;
    logic                stub_valid;
    logic [DW-1:0]       stub_sum;
    logic [DW-1:0]       pipe_sum [LAT];
    logic                pipe_v   [LAT];

    int checks = 0;
    int errors = 0;

    sum_rr_arbiter dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_enable         (i_enable),
        .i_req            (i_req),
        .i_req_dat        (i_req_dat),
        .o_gnt            (o_gnt),
        .o_sum_dat_vector (o_sum_dat_vector),
        .o_sum_dat_valid  (o_sum_dat_valid),
        .i_sum            (i_sum),
        .i_sum_valid      (i_sum_valid),
        .o_rsp_sum        (o_rsp_sum),
        .o_rsp_id         (o_rsp_id),
        .o_rsp_valid      (o_rsp_valid),
        .o_inflight       (o_inflight),
        .o_idle           (o_idle),
        .o_err            (o_err)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] vec_sum(input logic [NI*DW-1:0] v);
        logic [DW-1:0] s;
        s = '0;
        for (int k = 0; k < NI; k++) s = s + v[k*DW +: DW];
        return s;
    endfunction

    // Behavioural summer: LAT-stage pipeline sharing rst_n with the arbiter
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < LAT; k++) begin
                pipe_v[k]   <= 1'b0;
                pipe_sum[k] <= '0;
            end
        end else begin
            pipe_v[0]   <= o_sum_dat_valid;
            pipe_sum[0] <= vec_sum(o_sum_dat_vector);
            for (int k = 1; k < LAT; k++) begin
                pipe_v[k]   <= pipe_v[k-1];
                pipe_sum[k] <= pipe_sum[k-1];
            end
        end
    end

    assign i_sum_valid = stub_mode ? stub_valid : pipe_v[LAT-1];
    assign i_sum       = stub_mode ? stub_sum   : pipe_sum[LAT-1];

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_data(input int r, input int val);
        for (int k = 0; k < NI; k++) i_req_dat[(r*NI+k)*DW +: DW] = DW'(val);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        i_req = '0;
        i_enable = 1'b0;
        stub_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        i_enable = 1'b0;
        i_req = '0;
        i_req_dat = '0;
        stub_mode = 1'b0;
        stub_valid = 1'b0;
        stub_sum = '0;
        #1 rst_n = 1'b0;
        tick();
        tick();
        checks++; if (o_gnt !== '0) begin errors++; $display("FAIL reset_gnt: got %b expected 0000", o_gnt); end
        checks++; if (o_sum_dat_valid !== 1'b0 || o_rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valids: got dat_valid=%b rsp_valid=%b expected 0 0", o_sum_dat_valid, o_rsp_valid); end
        checks++; if (o_inflight !== 4'd0) begin errors++; $display("FAIL reset_inflight: got %0d expected 0", o_inflight); end
        checks++; if (o_idle !== 1'b1 || o_err !== 1'b0) begin errors++; $display("FAIL reset_idle_err: got idle=%b err=%b expected 1 0", o_idle, o_err); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        int grants;
        int rsps;
        logic [NI*DW-1:0] exp_vec;
        stub_mode = 1'b0;
        i_req_dat = '0;
        set_data(2, 1);
        for (int k = 0; k < NI; k++) exp_vec[k*DW +: DW] = DW'(1);
        grants = 0;
        rsps = 0;
        i_enable = 1'b1;
        i_req = 4'b0100;
        for (int c = 0; c < 40 && rsps == 0; c++) begin
            tick();
            if (o_gnt !== '0) begin
                grants++;
                checks++; if (o_gnt !== 4'b0100) begin errors++; $display("FAIL single_gnt: got %b expected 0100", o_gnt); end
                checks++; if (o_sum_dat_valid !== 1'b1 || o_sum_dat_vector !== exp_vec) begin errors++; $display("FAIL single_issue: got valid=%b vec=%h expected 1 %h", o_sum_dat_valid, o_sum_dat_vector, exp_vec); end
                i_req = '0;
            end
            if (o_rsp_valid) begin
                rsps++;
                checks++; if (o_rsp_sum !== 14'd16 || o_rsp_id !== 2'd2) begin errors++; $display("FAIL single_rsp: got sum=%0d id=%0d expected 16 2", o_rsp_sum, o_rsp_id); end
            end
        end
        checks++; if (grants !== 1 || rsps !== 1) begin errors++; $display("FAIL single_counts: got grants=%0d rsps=%0d expected 1 1", grants, rsps); end
        tick();
        checks++; if (o_inflight !== 4'd0) begin errors++; $display("FAIL single_inflight: got %0d expected 0", o_inflight); end
    endtask

    task automatic test_fairness();
        int gn;
        int rn;
        int exp_id;
        int exp_q[$];
        logic [NR-1:0] eg;
        apply_reset();
        stub_mode = 1'b0;
        for (int r = 0; r < NR; r++) set_data(r, r);
        gn = 0;
        rn = 0;
        i_enable = 1'b1;
        i_req = 4'b1111;
        for (int c = 0; c < 100 && rn < 12; c++) begin
            tick();
            if (o_gnt !== '0) begin
                eg = '0;
                eg[gn % NR] = 1'b1;
                checks++; if (o_gnt !== eg) begin errors++; $display("FAIL fair_order: grant %0d got %b expected %b", gn, o_gnt, eg); end
                exp_q.push_back(gn % NR);
                gn++;
                if (gn == 12) i_req = '0;
            end
            if (o_rsp_valid) begin
                exp_id = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
                checks++; if (32'(o_rsp_id) !== exp_id) begin errors++; $display("FAIL fair_id: rsp %0d got %0d expected %0d", rn, o_rsp_id, exp_id); end
                checks++; if (32'(o_rsp_sum) !== 16 * exp_id) begin errors++; $display("FAIL fair_sum: rsp %0d got %0d expected %0d", rn, o_rsp_sum, 16 * exp_id); end
                rn++;
            end
        end
        checks++; if (gn !== 12 || rn !== 12) begin errors++; $display("FAIL fair_counts: got grants=%0d rsps=%0d expected 12 12", gn, rn); end
    endtask

    task automatic test_credit();
        int gn;
        int extra;
        apply_reset();
        stub_mode = 1'b1;
        stub_valid = 1'b0;
        stub_sum = 14'h1abc;
        i_enable = 1'b1;
        i_req = 4'b1111;
        gn = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (o_gnt !== '0) gn++;
        end
        checks++; if (gn !== 8) begin errors++; $display("FAIL credit_grants: got %0d expected 8", gn); end
        checks++; if (o_inflight !== 4'd8 || o_gnt !== '0) begin errors++; $display("FAIL credit_full: got inflight=%0d gnt=%b expected 8 0000", o_inflight, o_gnt); end
        stub_valid = 1'b1;
        tick();
        stub_valid = 1'b0;
        checks++; if (o_inflight !== 4'd7 || o_gnt !== '0) begin errors++; $display("FAIL credit_pop: got inflight=%0d gnt=%b expected 7 0000", o_inflight, o_gnt); end
        checks++; if (o_rsp_valid !== 1'b1 || o_rsp_sum !== 14'h1abc || o_rsp_id !== 2'd0) begin errors++; $display("FAIL credit_rsp: got valid=%b sum=%h id=%0d expected 1 1abc 0", o_rsp_valid, o_rsp_sum, o_rsp_id); end
        tick();
        checks++; if ($countones(o_gnt) != 1 || o_inflight !== 4'd8) begin errors++; $display("FAIL credit_regrant: got gnt=%b inflight=%0d expected one-hot 8", o_gnt, o_inflight); end
        extra = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (o_gnt !== '0) extra++;
        end
        checks++; if (extra !== 0) begin errors++; $display("FAIL credit_extra: got %0d grants expected 0", extra); end
    endtask

    task automatic test_simultaneous();
        bit reached;
        apply_reset();
        stub_mode = 1'b1;
        stub_valid = 1'b0;
        stub_sum = 14'd77;
        i_enable = 1'b1;
        i_req = 4'b1111;
        reached = 1'b0;
        for (int c = 0; c < 20 && !reached; c++) begin
            tick();
            if (o_inflight == 4'd3) reached = 1'b1;
        end
        checks++; if (!reached) begin errors++; $display("FAIL simul_reach: got inflight=%0d expected 3", o_inflight); end
        stub_valid = 1'b1;
        tick();
        stub_valid = 1'b0;
        checks++; if (o_inflight !== 4'd3) begin errors++; $display("FAIL simul_inflight: got %0d expected 3", o_inflight); end
        checks++; if (o_gnt === '0 || o_rsp_valid !== 1'b1) begin errors++; $display("FAIL simul_both: got gnt=%b rsp_valid=%b expected nonzero 1", o_gnt, o_rsp_valid); end
        i_req = '0;
        tick();
        checks++; if (o_inflight !== 4'd3 || o_gnt !== '0) begin errors++; $display("FAIL simul_hold: got inflight=%0d gnt=%b expected 3 0000", o_inflight, o_gnt); end
    endtask

    // Continues from test_simultaneous: tags 1,2,3 remain in flight
    task automatic test_drain();
        i_enable = 1'b0;
        i_req = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            stub_sum = DW'(k + 5);
            stub_valid = 1'b1;
            tick();
            stub_valid = 1'b0;
            checks++; if (o_gnt !== '0 || o_idle !== 1'b0) begin errors++; $display("FAIL drain_pop%0d: got gnt=%b idle=%b expected 0000 0", k, o_gnt, o_idle); end
            checks++; if (o_rsp_valid !== 1'b1 || 32'(o_rsp_sum) !== k + 5 || 32'(o_rsp_id) !== k + 1) begin errors++; $display("FAIL drain_rsp%0d: got valid=%b sum=%0d id=%0d expected 1 %0d %0d", k, o_rsp_valid, o_rsp_sum, o_rsp_id, k + 5, k + 1); end
            tick();
            checks++; if (o_gnt !== '0 || o_idle !== (k == 2)) begin errors++; $display("FAIL drain_idle%0d: got gnt=%b idle=%b expected 0000 %0d", k, o_gnt, o_idle, (k == 2)); end
        end
        i_req = '0;
    endtask

    task automatic test_error();
        stub_mode = 1'b1;
        stub_sum = 14'd9;
        stub_valid = 1'b1;
        tick();
        stub_valid = 1'b0;
        checks++; if (o_err !== 1'b1 || o_rsp_valid !== 1'b0) begin errors++; $display("FAIL err_set: got err=%b rsp_valid=%b expected 1 0", o_err, o_rsp_valid); end
        checks++; if (o_inflight !== 4'd0) begin errors++; $display("FAIL err_inflight: got %0d expected 0", o_inflight); end
        tick();
        tick();
        checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b expected 1", o_err); end
    endtask

    task automatic test_reset_mid();
        stub_mode = 1'b1;
        stub_valid = 1'b0;
        i_enable = 1'b1;
        i_req = 4'b1111;
        for (int c = 0; c < 4; c++) tick();
        checks++; if (o_inflight !== 4'd3 || o_gnt === '0) begin errors++; $display("FAIL mid_pre: got inflight=%0d gnt=%b expected 3 nonzero", o_inflight, o_gnt); end
        rst_n = 1'b0;
        #1;
        checks++; if (o_gnt !== '0 || o_sum_dat_valid !== 1'b0 || o_sum_dat_vector !== '0) begin errors++; $display("FAIL mid_issue: got gnt=%b valid=%b vec=%h expected 0", o_gnt, o_sum_dat_valid, o_sum_dat_vector); end
        checks++; if (o_inflight !== 4'd0 || o_idle !== 1'b1 || o_err !== 1'b0) begin errors++; $display("FAIL mid_state: got inflight=%0d idle=%b err=%b expected 0 1 0", o_inflight, o_idle, o_err); end
        i_req = '0;
        i_enable = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_credit();
        test_simultaneous();
        test_drain();
        test_error();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
